adc_signal_conditioner: RTL and testbench

- Consumes the two raw 8-bit ADC channels produced by the SPI ADC controller: accelerator pot and CdS light sensor.
- Decimates both channels at a fixed sample rate and boxcar-averages them.
- Produces a dead-zoned throttle level and a debounced day/night flag with hysteresis for the vehicle model and the headlight logic.

---
 rtl/adc_cond_pkg.sv | 16 +
 rtl/adc_boxcar_avg.sv | 38 +++
 rtl/adc_signal_conditioner.sv | 180 ++++++++++++++++++
 tb/tb_adc_signal_conditioner.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/adc_cond_pkg.sv
// Types and constants shared by the ADC conditioning blocks: FSM encodings,
// the ADC data width and the rail codes that mark a stuck sensor.
package adc_cond_pkg;

   localparam int ADC_W = 8;
   localparam logic [ADC_W-1:0] RAIL_LO = 8'h00;
   localparam logic [ADC_W-1:0] RAIL_HI = 8'hFF;

   typedef enum logic {WARMUP, RUN} top_state_e;
   typedef enum logic {DAY, NIGHT} night_state_e;

   function automatic logic is_rail(input logic [ADC_W-1:0] v);
      return (v == RAIL_LO) || (v == RAIL_HI);
   endfunction

endpackage

// File: rtl/adc_boxcar_avg.sv
// One channel of the boxcar averager: circular window buffer plus running sum.
// avg_next_o is the average after the sample presented with load_i is folded in.
module adc_boxcar_avg
   import adc_cond_pkg::*;
#(
   parameter int AVG_LOG2 = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [ADC_W-1:0] sample_i,
   output logic [ADC_W-1:0] avg_next_o
);

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = ADC_W + AVG_LOG2;

   logic [ADC_W-1:0]    buf_q [DEPTH];
   logic [AVG_LOG2-1:0] wptr_q;
   logic [SUM_W-1:0]    sum_q, sum_d;

   // The oldest entry is always part of sum_q, so the subtraction cannot underflow.
   assign sum_d      = sum_q + SUM_W'(sample_i) - SUM_W'(buf_q[wptr_q]);
   assign avg_next_o = sum_d[SUM_W-1:AVG_LOG2];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         sum_q  <= '0;
         for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      end else if (load_i) begin
         wptr_q        <= wptr_q + 1'b1;
         sum_q         <= sum_d;
         buf_q[wptr_q] <= sample_i;
      end
   end

endmodule

// File: rtl/adc_signal_conditioner.sv
// Decimates and averages the accelerator and CdS ADC channels, producing a
// dead-zoned throttle and a debounced day/night flag. Stuck-rail detection on
// sensor_fault is built only when ADC_COND_STUCK_DET_EN is defined.
module adc_signal_conditioner
   import adc_cond_pkg::*;
#(
   parameter int SAMPLE_DIV     = 50000,
   parameter int AVG_LOG2       = 3,
   parameter int ACCEL_DEADZONE = 8,
   parameter int NIGHT_ON_TH    = 60,
   parameter int NIGHT_OFF_TH   = 90,
   parameter int NIGHT_HOLD     = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ADC_W-1:0] adc_accel,
   input  logic [ADC_W-1:0] adc_cds,
   output logic [ADC_W-1:0] accel_level,
   output logic [ADC_W-1:0] cds_avg,
   output logic             is_night,
   output logic             sample_valid,
   output logic             sensor_fault
);

   localparam int DEPTH  = 1 << AVG_LOG2;
   localparam int CNT_W  = $clog2(SAMPLE_DIV);
   localparam int FILL_W = AVG_LOG2 + 1;
   localparam int HOLD_W = $clog2(NIGHT_HOLD + 1);

   logic [CNT_W-1:0]  tick_cnt_q;
   logic              tick;
   logic [ADC_W-1:0]  accel_cap_q, cds_cap_q;
   logic              cap_vld_q;
   top_state_e        state_q, state_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   night_state_e      night_q, night_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              out_vld, qualify, fault_d;
   logic [ADC_W-1:0]  accel_avg_d, cds_avg_d, accel_dz_d;
   logic [ADC_W-1:0]  accel_level_q, cds_avg_q;
   logic              sample_valid_q, sensor_fault_q;

   assign tick = (tick_cnt_q == CNT_W'(SAMPLE_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q  <= '0;
         accel_cap_q <= '0;
         cds_cap_q   <= '0;
         cap_vld_q   <= 1'b0;
      end else begin
         tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
         cap_vld_q  <= tick;
         if (tick) begin
            accel_cap_q <= adc_accel;
            cds_cap_q   <= adc_cds;
         end
      end
   end

   adc_boxcar_avg #(.AVG_LOG2(AVG_LOG2)) u_accel_avg (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cap_vld_q),
      .sample_i   (accel_cap_q),
      .avg_next_o (accel_avg_d)
   );

   adc_boxcar_avg #(.AVG_LOG2(AVG_LOG2)) u_cds_avg (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cap_vld_q),
      .sample_i   (cds_cap_q),
      .avg_next_o (cds_avg_d)
   );

   // Warm-up: the sample that fills the window is the first one published.
   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      out_vld = 1'b0;
      if (cap_vld_q) begin
         case (state_q)
            WARMUP: begin
               fill_d = fill_q + 1'b1;
               if (fill_q == FILL_W'(DEPTH - 1)) begin
                  state_d = RUN;
                  out_vld = 1'b1;
               end
            end
            RUN:     out_vld = 1'b1;
            default: state_d = WARMUP;
         endcase
      end
   end

   always_comb begin
      night_d = night_q;
      hold_d  = hold_q;
      qualify = (night_q == DAY) ? (cds_avg_d < ADC_W'(NIGHT_ON_TH))
                                 : (cds_avg_d > ADC_W'(NIGHT_OFF_TH));
      if (out_vld) begin
         if (!qualify) begin
            hold_d = '0;
         end else if (hold_q >= HOLD_W'(NIGHT_HOLD - 1)) begin
            night_d = (night_q == DAY) ? NIGHT : DAY;
            hold_d  = '0;
         end else begin
            hold_d = hold_q + 1'b1;
         end
      end
   end

   assign accel_dz_d = (accel_avg_d > ADC_W'(ACCEL_DEADZONE)) ?
                       accel_avg_d - ADC_W'(ACCEL_DEADZONE) : '0;

`ifdef ADC_COND_STUCK_DET_EN
   localparam int STUCK_LIM = 4 << AVG_LOG2;
   localparam int STUCK_W   = $clog2(STUCK_LIM + 1);

   logic [STUCK_W-1:0] accel_stuck_q, accel_stuck_d, cds_stuck_q, cds_stuck_d;

   // Saturating run-length of consecutive rail captures per channel.
   always_comb begin
      accel_stuck_d = accel_stuck_q;
      cds_stuck_d   = cds_stuck_q;
      if (cap_vld_q) begin
         accel_stuck_d = !is_rail(accel_cap_q) ? '0 :
                         (accel_stuck_q == STUCK_W'(STUCK_LIM)) ? accel_stuck_q : accel_stuck_q + 1'b1;
         cds_stuck_d   = !is_rail(cds_cap_q) ? '0 :
                         (cds_stuck_q == STUCK_W'(STUCK_LIM)) ? cds_stuck_q : cds_stuck_q + 1'b1;
      end
   end

   assign fault_d = (accel_stuck_d == STUCK_W'(STUCK_LIM)) || (cds_stuck_d == STUCK_W'(STUCK_LIM));

   always_ff @(posedge clk) begin
      if (rst) begin
         accel_stuck_q <= '0;
         cds_stuck_q   <= '0;
      end else begin
         accel_stuck_q <= accel_stuck_d;
         cds_stuck_q   <= cds_stuck_d;
      end
   end
`else
   assign fault_d = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= WARMUP;
         fill_q         <= '0;
         night_q        <= DAY;
         hold_q         <= '0;
         accel_level_q  <= '0;
         cds_avg_q      <= '0;
         sample_valid_q <= 1'b0;
         sensor_fault_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         fill_q         <= fill_d;
         night_q        <= night_d;
         hold_q         <= hold_d;
         sample_valid_q <= out_vld;
         if (out_vld) begin
            accel_level_q  <= fault_d ? '0 : accel_dz_d;
            cds_avg_q      <= cds_avg_d;
            sensor_fault_q <= fault_d;
         end
      end
   end

   assign accel_level  = accel_level_q;
   assign cds_avg      = cds_avg_q;
   assign is_night     = (night_q == NIGHT);
   assign sample_valid = sample_valid_q;
   assign sensor_fault = sensor_fault_q;

endmodule

// File: tb/tb_adc_signal_conditioner.sv
// Directed bench for adc_signal_conditioner with a short sample period and a
// 4-deep window; expected averages are hand-computed from the last four raw values.
module tb_adc_signal_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] adc_accel, adc_cds;
   logic [7:0] accel_level, cds_avg;
   logic       is_night, sample_valid, sensor_fault;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   adc_signal_conditioner #(
      .SAMPLE_DIV     (4),
      .AVG_LOG2       (2),
      .ACCEL_DEADZONE (8),
      .NIGHT_ON_TH    (60),
      .NIGHT_OFF_TH   (90),
      .NIGHT_HOLD     (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .adc_accel    (adc_accel),
      .adc_cds      (adc_cds),
      .accel_level  (accel_level),
      .cds_avg      (cds_avg),
      .is_night     (is_night),
      .sample_valid (sample_valid),
      .sensor_fault (sensor_fault)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // Waits (bounded) for the next sample_valid, sampling on the falling edge.
   task automatic wait_valid(output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!sample_valid && cycles < 40);
      if (!sample_valid) check("valid_timeout", sample_valid, 1);
      $display("sample: accel=%0d cds=%0d -> accel_level=%0d cds_avg=%0d is_night=%0d fault=%0d",
               adc_accel, adc_cds, accel_level, cds_avg, is_night, sensor_fault);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_accel_level"},  accel_level,  0);
      check({tag, "_cds_avg"},      cds_avg,      0);
      check({tag, "_is_night"},     is_night,     0);
      check({tag, "_sample_valid"}, sample_valid, 0);
      check({tag, "_sensor_fault"}, sensor_fault, 0);
   endtask

   int step_exp   [6]  = '{42, 92, 142, 192, 192, 192};
   int zero_exp   [4]  = '{67, 42, 17, 0};
   int low_exp    [5]  = '{143, 94, 45, 0, 0};
   int dusk_avg   [6]  = '{160, 120, 80, 40, 40, 40};
   int dusk_night [6]  = '{0, 0, 0, 0, 0, 1};
   int mid_avg    [4]  = '{48, 57, 66, 75};
   int dawn_raw   [7]  = '{200, 75, 10, 75, 250, 250, 250};
   int dawn_avg   [7]  = '{106, 106, 90, 90, 102, 146, 206};
   int dawn_night [7]  = '{1, 1, 1, 1, 1, 1, 0};
   int eq_avg     [6]  = '{202, 155, 107, 60, 60, 60};

   initial begin
      int n;
      rst       = 1'b1;
      adc_accel = 8'd100;
      adc_cds   = 8'd200;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;

      wait_valid(n);
      check("first_valid_latency", n, 17);
      check("warm_accel_level", accel_level, 92);
      check("warm_cds_avg", cds_avg, 200);
      check("warm_is_night", is_night, 0);
      check("warm_sensor_fault", sensor_fault, 0);
      @(negedge clk);
      check("valid_pulse_width", sample_valid, 0);

      adc_accel = 8'd0;
      for (int i = 0; i < 4; i++) begin
         wait_valid(n);
         check($sformatf("accel_to_zero_%0d", i), accel_level, zero_exp[i]);
      end
      adc_accel = 8'd200;
      for (int i = 0; i < 6; i++) begin
         wait_valid(n);
         check($sformatf("accel_step_%0d", i), accel_level, step_exp[i]);
      end
      adc_accel = 8'd5;
      for (int i = 0; i < 5; i++) begin
         wait_valid(n);
         check($sformatf("accel_deadzone_%0d", i), accel_level, low_exp[i]);
      end

      adc_cds = 8'd40;
      for (int i = 0; i < 6; i++) begin
         wait_valid(n);
         check($sformatf("dusk_cds_avg_%0d", i), cds_avg, dusk_avg[i]);
         check($sformatf("dusk_is_night_%0d", i), is_night, dusk_night[i]);
      end
      adc_cds = 8'd75;
      for (int i = 0; i < 4; i++) begin
         wait_valid(n);
         check($sformatf("between_cds_avg_%0d", i), cds_avg, mid_avg[i]);
         check($sformatf("between_is_night_%0d", i), is_night, 1);
      end
      for (int i = 0; i < 7; i++) begin
         adc_cds = 8'(dawn_raw[i]);
         wait_valid(n);
         check($sformatf("dawn_cds_avg_%0d", i), cds_avg, dawn_avg[i]);
         check($sformatf("dawn_is_night_%0d", i), is_night, dawn_night[i]);
      end
      adc_cds = 8'd60;
      for (int i = 0; i < 6; i++) begin
         wait_valid(n);
         check($sformatf("on_th_equal_cds_avg_%0d", i), cds_avg, eq_avg[i]);
         check($sformatf("on_th_equal_is_night_%0d", i), is_night, 0);
      end

      @(negedge clk);
      rst       = 1'b1;
      adc_accel = 8'd100;
      adc_cds   = 8'd200;
      @(negedge clk);
      check_zero("mid_reset");
      rst = 1'b0;
      wait_valid(n);
      check("rewarm_latency", n, 17);
      check("rewarm_accel_level", accel_level, 92);
      check("rewarm_cds_avg", cds_avg, 200);

      adc_accel = 8'hFF;
      for (int i = 1; i <= 16; i++) begin
         wait_valid(n);
         if (i == 15) begin
            check("stuck_15_fault", sensor_fault, 0);
            check("stuck_15_accel_level", accel_level, 247);
         end
      end
`ifdef ADC_COND_STUCK_DET_EN
      check("stuck_16_fault", sensor_fault, 1);
      check("stuck_16_accel_level", accel_level, 0);
`else
      check("stuck_16_fault", sensor_fault, 0);
      check("stuck_16_accel_level", accel_level, 247);
`endif
      adc_accel = 8'h80;
      wait_valid(n);
      check("unstuck_fault", sensor_fault, 0);
      check("unstuck_accel_level", accel_level, 215);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
